// File: rtl/fb_rd_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : fb_rd_ctrl_if
// Description : Bus bundle for the frame-buffer read controller. It carries
//               the read port towards data_mem and the valid/ready output
//               stream towards the downstream consumer.
//
//   Signals
//     rd_en      read strobe to data_mem            (controller -> memory)
//     rd_addr    read address to data_mem           (controller -> memory)
//     rd_data    read data, one cycle after rd_en   (memory -> controller)
//     out_data   streamed word                      (controller -> sink)
//     out_valid  out_data valid                     (controller -> sink)
//     out_ready  sink accepts the word              (sink -> controller)
//     out_last   final word of a frame              (controller -> sink)
//
//   Modports
//     master     the controller side
//     slave      the memory / sink side
//
// Revision    : 1.0 - initial release
// ============================================================================

interface fb_rd_ctrl_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3
);

  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;

  modport master (
    output rd_en,
    output rd_addr,
    input  rd_data,
    output out_data,
    output out_valid,
    input  out_ready,
    output out_last
  );

  modport slave (
    input  rd_en,
    input  rd_addr,
    output rd_data,
    input  out_data,
    input  out_valid,
    output out_ready,
    input  out_last
  );

endinterface

`default_nettype wire

// File: rtl/fb_rd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fb_rd_ctrl
// Description : Frame-buffer read controller. On a start pulse it reads
//               FRAME_LEN consecutive words from a one-cycle-latency memory
//               (addresses 0..FRAME_LEN-1) and streams them out over a
//               valid/ready interface, marking the final word with out_last
//               and pulsing frame_done after it has transferred.
//
//   Parameters
//     DATA_WIDTH  word width in bits
//     ADDR_WIDTH  memory address width in bits
//     FRAME_LEN   words per frame, 1..2**ADDR_WIDTH
//
//   Ports
//     clk         clock, rising edge
//     reset       synchronous active-high reset
//     start       one-cycle pulse requesting a frame read-out (IDLE only)
//     busy        high from the cycle after an accepted start until the
//                 last word of the frame has transferred
//     frame_done  one-cycle pulse the cycle after the last-word transfer
//     bus         fb_rd_ctrl_if.master (memory read port + output stream)
//
//   Build option
//     FB_RD_CTRL_WRAP_EN  when defined, the read-out wraps back to address 0
//                         after FRAME_LEN-1 and keeps streaming frames until
//                         reset; out_last and frame_done still mark every
//                         frame boundary. When undefined the controller is
//                         single-shot and contains no wrap logic.
//
// Revision    : 1.0 - initial release
// ============================================================================

module fb_rd_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3,
  parameter int FRAME_LEN  = 8
) (
  input  wire          clk,
  input  wire          reset,
  input  wire          start,
  output logic         busy,
  output logic         frame_done,
  fb_rd_ctrl_if.master bus
);

  // --------------------------------------------------------------------------
  // Elaboration-time parameter sanity check
  // --------------------------------------------------------------------------
  generate
    if ((FRAME_LEN < 1) || (FRAME_LEN > (1 << ADDR_WIDTH))) begin : g_bad_frame_len
      $error("fb_rd_ctrl: FRAME_LEN must lie in 1..2**ADDR_WIDTH");
    end
  endgenerate

  localparam logic [ADDR_WIDTH-1:0] c_last_addr = ADDR_WIDTH'(FRAME_LEN - 1);

  // --------------------------------------------------------------------------
  // State encoding
  //   S_IDLE  : waiting for start
  //   S_READ  : addresses still to be issued
  //   S_DRAIN : every address issued, words still to leave the buffer
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_busy;
  logic                  r_frame_done;

  // One read may be in flight: r_inflight means rd_data carries a word this
  // cycle, r_inflight_last tags it as the final word of a frame.
  logic                  r_inflight;
  logic                  r_inflight_last;

  // Two-entry output buffer kept as a tiny shift register: entry 0 is the
  // head, entry 1 only ever holds a word while entry 0 is occupied.
  logic [1:0]            r_cnt;
  logic [DATA_WIDTH-1:0] r_buf0;
  logic [DATA_WIDTH-1:0] r_buf1;
  logic                  r_last0;
  logic                  r_last1;

  logic                  w_pop;
  logic                  w_push;
  logic                  w_rd_en;
  logic                  w_issue_last;
  logic [2:0]            w_level;

  // --------------------------------------------------------------------------
  // Output stream
  // With the buffer empty the returning memory word is presented directly,
  // which gives the two-cycle start-to-valid latency. If that word is not
  // accepted it is pushed into the buffer and re-presented from entry 0 on
  // the next cycle, so the visible value does not change while stalled.
  // --------------------------------------------------------------------------
  always_comb begin
    bus.out_valid = (r_cnt != 2'd0) || r_inflight;
    bus.out_data  = '0;
    bus.out_last  = 1'b0;
    if (r_cnt != 2'd0) begin
      bus.out_data = r_buf0;
      bus.out_last = r_last0;
    end else if (r_inflight) begin
      bus.out_data = bus.rd_data;
      bus.out_last = r_inflight_last;
    end
  end

  assign w_pop = bus.out_valid & bus.out_ready;

  // The returning word only needs storage when it is not leaving right away
  // through the bypass path.
  assign w_push = r_inflight & ~((r_cnt == 2'd0) & w_pop);

  // Words held or in flight once this cycle's transfer is accounted for.
  // A new read is issued only if it still fits in the two-entry buffer.
  assign w_level = {1'b0, r_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};

  assign w_rd_en      = (r_state == S_READ) && (w_level < 3'd2);
  assign w_issue_last = w_rd_en && (r_addr == c_last_addr);

  assign bus.rd_en   = w_rd_en;
  assign bus.rd_addr = r_addr;
  assign busy        = r_busy;
  assign frame_done  = r_frame_done;

  // --------------------------------------------------------------------------
  // Read tracking and output buffer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      // Clearing r_inflight also discards any word still returning from a
      // read that was issued before the reset.
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_cnt           <= 2'd0;
      r_buf0          <= '0;
      r_buf1          <= '0;
      r_last0         <= 1'b0;
      r_last1         <= 1'b0;
    end else begin
      r_inflight      <= w_rd_en;
      r_inflight_last <= w_issue_last;

      case (r_cnt)
        2'd0: begin
          if (w_push) begin
            r_buf0  <= bus.rd_data;
            r_last0 <= r_inflight_last;
            r_cnt   <= 2'd1;
          end
        end
        2'd1: begin
          if (w_pop && w_push) begin
            r_buf0  <= bus.rd_data;
            r_last0 <= r_inflight_last;
          end else if (w_pop) begin
            r_cnt <= 2'd0;
          end else if (w_push) begin
            r_buf1  <= bus.rd_data;
            r_last1 <= r_inflight_last;
            r_cnt   <= 2'd2;
          end
        end
        default: begin
          // Full: a push can only coincide with a pop here, since the issue
          // throttle never lets a third word be requested.
          if (w_pop) begin
            r_buf0  <= r_buf1;
            r_last0 <= r_last1;
            if (w_push) begin
              r_buf1  <= bus.rd_data;
              r_last1 <= r_inflight_last;
            end else begin
              r_cnt <= 2'd1;
            end
          end
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_pop & bus.out_last;

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_READ;
            r_addr  <= '0;
            r_busy  <= 1'b1;
          end
        end

        S_READ: begin
          if (w_rd_en) begin
            if (r_addr == c_last_addr) begin
              // Address returns to 0, ready for the next frame.
              r_addr <= '0;
`ifdef FB_RD_CTRL_WRAP_EN
              r_state <= S_READ;
`else
              r_state <= S_DRAIN;
`endif
            end else begin
              r_addr <= r_addr + 1'b1;
            end
          end
        end

        S_DRAIN: begin
          if (w_pop && bus.out_last) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fb_rd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fb_rd_ctrl
// Description : Self-checking bench for fb_rd_ctrl. A one-cycle-latency
//               memory preloaded with addr+1 feeds the controller; a
//               reference model tracks the expected word order, frame
//               boundaries, busy/frame_done and buffer bound while out_ready
//               is driven constant, toggling, randomly or in a directed stall.
//               A second instance with FRAME_LEN=1 covers the one-word frame.
//               Build with FB_RD_CTRL_WRAP_EN to exercise the wrapping mode.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_fb_rd_ctrl;

  localparam int DW = 16;
  localparam int AW = 3;
  localparam int FL = 8;
`ifdef FB_RD_CTRL_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic busy;
  logic frame_done;
  logic busy2;
  logic frame_done2;

  fb_rd_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus  ();
  fb_rd_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus2 ();

  fb_rd_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FRAME_LEN(FL)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .busy       (busy),
    .frame_done (frame_done),
    .bus        (bus)
  );

  fb_rd_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FRAME_LEN(1)) dut_fl1 (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .busy       (busy2),
    .frame_done (frame_done2),
    .bus        (bus2)
  );

  always #5 clk = ~clk;

  // One-cycle-latency memory, contents addr+1
  logic [DW-1:0] mem [0:(1<<AW)-1];
  initial for (int i = 0; i < (1 << AW); i++) mem[i] = DW'(i + 1);
  always @(posedge clk) if (bus.rd_en)  bus.rd_data  <= mem[bus.rd_addr];
  always @(posedge clk) if (bus2.rd_en) bus2.rd_data <= mem[bus2.rd_addr];

  // --------------------------------------------------------------------------
  // Checking
  // --------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model (updated once per cycle at the falling edge)
  // --------------------------------------------------------------------------
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit      mon_en      = 1'b0;
  bit      expect_zero = 1'b1;
  bit      exp_fd      = 1'b0;
  bit      m_busy      = 1'b0;
  int      exp_addr    = 0;
  int      exp_idx     = 0;
  int      m_issued    = 0;
  int      outstanding = 0;
  bit      prev_stall  = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic    prev_last   = 1'b0;
  int      n_xfer      = 0;
  int      n_frames    = 0;
  int      start_cyc   = -1;
  int      first_rden  = -1;
  int      first_valid = -1;
  int      last_xfer   = -1;
  int      fd_cyc      = -1;

  always @(negedge clk) begin : model
    logic pop;
    logic was_busy;
    logic can_issue;
    if (mon_en) begin
      pop       = bus.out_valid && bus.out_ready;
      was_busy  = m_busy;
      can_issue = m_busy && (WRAP || (m_issued < FL));

      if (expect_zero) begin
        check("rst_rd_en",      32'(bus.rd_en),     32'd0);
        check("rst_rd_addr",    32'(bus.rd_addr),   32'd0);
        check("rst_out_valid",  32'(bus.out_valid), 32'd0);
        check("rst_out_data",   32'(bus.out_data),  32'd0);
        check("rst_out_last",   32'(bus.out_last),  32'd0);
        check("rst_busy",       32'(busy),          32'd0);
        check("rst_frame_done", 32'(frame_done),    32'd0);
      end
      check("frame_done", 32'(frame_done), 32'(exp_fd));
      check("busy", 32'(busy), 32'(m_busy));
      check("rd_en_spurious", 32'(bus.rd_en && !can_issue), 32'd0);
      if (bus.rd_en) check("rd_addr", 32'(bus.rd_addr), 32'(exp_addr));
      check("buffer_bound",
            32'((outstanding + (bus.rd_en ? 1 : 0) - (pop ? 1 : 0)) <= 2), 32'd1);
      if (prev_stall) begin
        check("stall_valid", 32'(bus.out_valid), 32'd1);
        check("stall_data",  32'(bus.out_data),  32'(prev_data));
        check("stall_last",  32'(bus.out_last),  32'(prev_last));
      end
      if (pop) begin
        check("out_data", 32'(bus.out_data), 32'(exp_idx + 1));
        check("out_last", 32'(bus.out_last), 32'(exp_idx == FL - 1));
        check("pop_has_word", 32'(outstanding > 0), 32'd1);
      end

      if (bus.rd_en && first_rden < 0) first_rden = cyc;
      if (bus.out_valid && first_valid < 0 && start_cyc >= 0) first_valid = cyc;
      if (frame_done && fd_cyc < 0 && start_cyc >= 0) fd_cyc = cyc;

      if (reset) begin
        m_busy = 0; exp_addr = 0; exp_idx = 0; m_issued = 0; outstanding = 0;
        exp_fd = 0; prev_stall = 0; expect_zero = 1;
      end else begin
        expect_zero = 0;
        exp_fd      = pop && (exp_idx == FL - 1);
        prev_stall  = bus.out_valid && !bus.out_ready;
        prev_data   = bus.out_data;
        prev_last   = bus.out_last;
        if (bus.rd_en) begin
          exp_addr = (exp_addr + 1) % FL;
          m_issued++;
          outstanding++;
        end
        if (pop) begin
          outstanding--;
          n_xfer++;
          if (exp_idx == FL - 1) begin
            n_frames++;
            if (last_xfer < 0 && start_cyc >= 0) last_xfer = cyc;
            if (!WRAP) m_busy = 0;
            exp_idx = 0;
          end else begin
            exp_idx++;
          end
        end
        if (!was_busy && start) begin
          m_busy = 1; exp_addr = 0; m_issued = 0; start_cyc = cyc;
          first_rden = -1; first_valid = -1; last_xfer = -1; fd_cyc = -1;
        end
      end
    end
  end

  // FRAME_LEN=1 instance: every transferred word is word 0 and is last.
  int n2_xfer  = 0;
  int n2_fd    = 0;
  int n2_cyc   = -1;
  always @(negedge clk) begin
    if (mon_en && !reset) begin
      if (bus2.out_valid && bus2.out_ready) begin
        check("fl1_data", 32'(bus2.out_data), 32'd1);
        check("fl1_last", 32'(bus2.out_last), 32'd1);
        n2_xfer++;
        n2_cyc = cyc;
      end
      if (frame_done2) n2_fd++;
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  int mode = 0;   // 0 hold, 1 toggle, 2 random, 3 directed

  task automatic tick();
    @(posedge clk);
    #1;
    case (mode)
      1:       bus.out_ready = !bus.out_ready;
      2:       bus.out_ready = (($urandom % 4) != 0);
      default: ;
    endcase
  endtask

  task automatic pulse_start();
    tick(); start = 1'b1;
    tick(); start = 1'b0;
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n;
    n = 0;
    while (n_frames < target && n < budget) begin
      tick();
      n++;
    end
    check("frame_timeout", 32'(n_frames >= target), 32'd1);
  endtask

  initial begin : watchdog
    #60000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int f0, x0, x1, f2, x2;
    bit stalled, saw_rd_off;
    reset = 1'b1; start = 1'b0;
    bus.out_ready = 1'b1; bus2.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 mon_en = 1'b1;
    tick(); reset = 1'b0;
    repeat (2) tick();

    // Full frame with out_ready held high: latency and throughput
    mode = 0; bus.out_ready = 1'b1;
    f0 = n_frames; x0 = n_xfer;
    pulse_start();
`ifdef FB_RD_CTRL_WRAP_EN
    wait_frames(f0 + 3, 200);
    check("wrap_frames", 32'(n_frames - f0), 32'd3);
    check("wrap_xfers",  32'(n_xfer - x0),   32'd24);
    check("wrap_busy",   32'(busy),          32'd1);
`else
    wait_frames(f0 + 1, 100);
    repeat (3) tick();
    check("t1_xfers", 32'(n_xfer - x0), 32'd8);
    check("t1_busy_low", 32'(busy), 32'd0);
`endif
    check("t1_first_rd_en", 32'(first_rden - start_cyc),  32'd1);
    check("t1_first_valid", 32'(first_valid - start_cyc), 32'd2);
    check("t1_last_xfer",   32'(last_xfer - start_cyc),   32'd9);
    check("t1_frame_done",  32'(fd_cyc - start_cyc),      32'd10);

`ifdef FB_RD_CTRL_WRAP_EN
    // Random backpressure while wrapping, then reset stops the read-out
    mode = 2;
    repeat (80) tick();
    reset = 1'b1; tick(); reset = 1'b0;
    mode = 0; bus.out_ready = 1'b1;
    repeat (5) tick();
    check("wrap_stopped_busy", 32'(busy), 32'd0);
`else
    // Directed stall: out_ready low for 3 cycles starting when 0x0003 shows
    mode = 3; bus.out_ready = 1'b1;
    f0 = n_frames; stalled = 0; saw_rd_off = 0;
    pulse_start();
    for (int i = 0; i < 40 && !stalled; i++) begin
      tick();
      if (bus.out_valid && bus.out_data == 16'h0003) begin
        stalled = 1;
        bus.out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          if (!bus.rd_en) saw_rd_off = 1;
          @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
      end
    end
    check("t2_stall_hit", 32'(stalled), 32'd1);
    check("t2_rd_en_off", 32'(saw_rd_off), 32'd1);
    wait_frames(f0 + 1, 100);
    repeat (3) tick();

    // out_ready toggling every cycle
    mode = 1; bus.out_ready = 1'b1;
    f0 = n_frames; x0 = n_xfer;
    pulse_start();
    wait_frames(f0 + 1, 100);
    repeat (5) tick();
    check("t3_xfers",  32'(n_xfer - x0),   32'd8);
    check("t3_frames", 32'(n_frames - f0), 32'd1);

    // Reset after the third transfer, then a fresh frame
    mode = 2;
    f0 = n_frames; x0 = n_xfer;
    pulse_start();
    for (int i = 0; i < 100 && (n_xfer - x0) < 3; i++) tick();
    check("t4_reached_3", 32'(n_xfer - x0 >= 3), 32'd1);
    reset = 1'b1; tick(); reset = 1'b0;
    repeat (4) tick();
    check("t4_no_frame", 32'(n_frames - f0), 32'd0);
    x1 = n_xfer;
    pulse_start();
    wait_frames(f0 + 1, 150);
    repeat (5) tick();
    check("t4_fresh_xfers", 32'(n_xfer - x1), 32'd8);

    // Reset and start together: reset wins
    tick(); reset = 1'b1; start = 1'b1;
    tick(); reset = 1'b0; start = 1'b0;
    repeat (4) tick();
    check("t5_rst_over_start", 32'(busy), 32'd0);

    // start pulsed repeatedly while busy is ignored
    f0 = n_frames; x0 = n_xfer;
    pulse_start();
    for (int i = 0; i < 200 && n_frames == f0; i++) begin
      tick();
      start = busy && (($urandom % 3) == 0);
    end
    start = 1'b0;
    repeat (8) tick();
    check("t6_frames", 32'(n_frames - f0), 32'd1);
    check("t6_xfers",  32'(n_xfer - x0),   32'd8);

    // FRAME_LEN=1 instance: one word, last, frame_done next cycle
    mode = 0; bus.out_ready = 1'b1;
    f0 = n_frames; f2 = n2_fd; x2 = n2_xfer;
    pulse_start();
    wait_frames(f0 + 1, 100);
    repeat (4) tick();
    check("fl1_xfers",      32'(n2_xfer - x2),       32'd1);
    check("fl1_frame_done", 32'(n2_fd - f2),         32'd1);
    check("fl1_latency",    32'(n2_cyc - start_cyc), 32'd2);
    check("fl1_busy_low",   32'(busy2),              32'd0);
`endif

    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
